// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
package dmem_pkg;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    WIDTH_WORD = 2'b00,
    WIDTH_HALF = 2'b01,
    WIDTH_BYTE = 2'b10,
    WIDTH_RSVD = 2'b11
  } width_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  function automatic logic isAligned(input logic [1:0] width, input logic [1:0] addrLo);
    case (width)
      WIDTH_HALF: return ~addrLo[0];
      WIDTH_BYTE: return 1'b1;
      default:    return addrLo == 2'b00;
    endcase
  endfunction

  function automatic logic [NUM_LANES-1:0] laneEnable(input logic [1:0] width, input logic [1:0] addrLo);
    case (width)
      WIDTH_HALF: return addrLo[1] ? 4'b1100 : 4'b0011;
      WIDTH_BYTE: return 4'b0001 << addrLo;
      default:    return 4'b1111;
    endcase
  endfunction

  // Sub-word store data sits in the LSBs; replicate it so every lane sees it.
  function automatic logic [31:0] steerData(input logic [1:0] width, input logic [31:0] data);
    case (width)
      WIDTH_HALF: return {2{data[15:0]}};
      WIDTH_BYTE: return {4{data[7:0]}};
      default:    return data;
    endcase
  endfunction
endpackage

// File: rtl/dmem_if.sv
// Memory-stage to data-memory bus.
interface dmem_if;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [1:0]  WidthSrcM;
  logic        MemWriteM;
  logic        MemReqM;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        MisalignM;

  modport master (
    output ALUResultM, WriteDataM, WidthSrcM, MemWriteM, MemReqM,
    input  ReadDataM, MemStallM, MisalignM
  );
  modport slave (
    input  ALUResultM, WriteDataM, WidthSrcM, MemWriteM, MemReqM,
    output ReadDataM, MemStallM, MisalignM
  );
endinterface

// File: rtl/dmem_array.sv
// Byte-lane RAM: synchronous write with per-lane enable, synchronous read, no reset.
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                       clk,
  input  logic [AW-1:0]              addr,
  input  logic                       we,
  input  logic [NUM_LANES-1:0]       be,
  input  logic [NUM_LANES-1:0][7:0]  wdata,
  input  logic                       re,
  output logic [NUM_LANES-1:0][7:0]  rdata
);
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rdLane;

    always_ff @(posedge clk) begin
      if (we && be[l]) mem[addr] <= wdata[l];
      if (re)          rdLane    <= mem[addr];
    end

    assign rdata[l] = rdLane;
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: wait-state FSM, store lane steering, aligned-word loads.
// Optional load/store counters when DMEM_PERF_CNT_EN is defined.
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  dmem_if.slave       bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] LoadCountM,
  output logic [31:0] StoreCountM
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);
  // IDLE and DONE already account for two cycles; BUSY covers the remaining WAIT_CYCLES-1+1.
  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e                     state;
  logic [3:0]                 cnt;
  logic                       misFlag;
  logic                       rdValid;
  logic                       aligned;
  logic                       commit;
  logic                       commitLoad;
  logic                       commitStore;
  logic [NUM_LANES-1:0][7:0]  rdWord;

  assign aligned = isAligned(bus.WidthSrcM, bus.ALUResultM[1:0]);

  // With zero wait states the access commits straight out of IDLE.
  always_comb begin
    commit = 1'b0;
    case (state)
      IDLE:    commit = (WAIT_CYCLES == 0) && bus.MemReqM && aligned;
      BUSY:    commit = (cnt == 4'd0);
      default: commit = 1'b0;
    endcase
  end

  assign commitStore = commit &&  bus.MemWriteM;
  assign commitLoad  = commit && !bus.MemWriteM;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      misFlag <= 1'b0;
      rdValid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.MemReqM) begin
          if (!aligned) begin
            misFlag <= 1'b1;
            state   <= DONE;
          end else if (commit) begin
            state   <= DONE;
          end else begin
            cnt     <= CNT_INIT;
            state   <= BUSY;
          end
        end
        BUSY: if (commit) state <= DONE;
              else        cnt   <= cnt - 4'd1;
        default: begin
          misFlag <= 1'b0;
          state   <= IDLE;
        end
      endcase
      if (commitLoad) rdValid <= 1'b1;
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) uArray (
    .clk   (clk),
    .addr  (bus.ALUResultM[AW+1:2]),
    .we    (commitStore),
    .be    (laneEnable(bus.WidthSrcM, bus.ALUResultM[1:0])),
    .wdata (steerData(bus.WidthSrcM, bus.WriteDataM)),
    .re    (commitLoad),
    .rdata (rdWord)
  );

  // The RAM read register has no reset, so gate it until the first load lands.
  assign bus.ReadDataM = rdValid ? rdWord : 32'h0;
  assign bus.MemStallM = (state == IDLE) ? bus.MemReqM : (state == BUSY);
  assign bus.MisalignM = misFlag;

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LoadCountM  <= '0;
      StoreCountM <= '0;
    end else begin
      if (commitLoad)  LoadCountM  <= LoadCountM + 32'd1;
      if (commitStore) StoreCountM <= StoreCountM + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed + random bench for dmem_responder (WAIT_CYCLES=1 and WAIT_CYCLES=0 instances).
module tb_dmem_responder;
  localparam int W1 = 1;
  localparam int W0 = 0;

  logic clk = 1'b0;
  logic reset1, reset0;
  int   total = 0;
  int   bad   = 0;

  dmem_if i1();
  dmem_if i0();

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] ldc1, stc1, ldc0, stc0;
`endif

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .reset(reset1), .bus(i1)
`ifdef DMEM_PERF_CNT_EN
    , .LoadCountM(ldc1), .StoreCountM(stc1)
`endif
  );
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .reset(reset0), .bus(i0)
`ifdef DMEM_PERF_CNT_EN
    , .LoadCountM(ldc0), .StoreCountM(stc0)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: word store keyed by dut*4096 + word index.
  logic [31:0] mdl [int];
  logic [31:0] lastRd [2];
  int unsigned ldCnt [2];
  int unsigned stCnt [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] wd, input logic wr, input logic rq);
    if (w == 1) begin
      i1.ALUResultM = a; i1.WriteDataM = d; i1.WidthSrcM = wd; i1.MemWriteM = wr; i1.MemReqM = rq;
    end else begin
      i0.ALUResultM = a; i0.WriteDataM = d; i0.WidthSrcM = wd; i0.MemWriteM = wr; i0.MemReqM = rq;
    end
  endtask

  task automatic idle(input int w);
    drive(w, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
  endtask

  function automatic logic stallOf(input int w);
    return (w == 1) ? i1.MemStallM : i0.MemStallM;
  endfunction
  function automatic logic misOf(input int w);
    return (w == 1) ? i1.MisalignM : i0.MisalignM;
  endfunction
  function automatic logic [31:0] rdOf(input int w);
    return (w == 1) ? i1.ReadDataM : i0.ReadDataM;
  endfunction

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after DONE.
  task automatic access(input int w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] wd, input logic wr, input string tag);
    int cyc, stN, misN, key, sh, expTot;
    logic al;
    logic [31:0] old;
    al  = (wd == 2'b10) || (wd == 2'b01 && a[0] == 1'b0) ||
          ((wd == 2'b00 || wd == 2'b11) && a[1:0] == 2'b00);
    key = w * 4096 + int'(a[11:2]);
    if (al) begin
      if (wr) begin
        old = mdl.exists(key) ? mdl[key] : 32'h0;
        if (wd == 2'b10) begin
          sh = int'(a[1:0]) * 8;
          mdl[key] = (old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        end else if (wd == 2'b01) begin
          sh = int'(a[1]) * 16;
          mdl[key] = (old & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
        end else begin
          mdl[key] = d;
        end
        stCnt[w]++;
      end else begin
        lastRd[w] = mdl[key];
        ldCnt[w]++;
      end
    end
    expTot = al ? ((w == 1) ? W1 : W0) + 2 : 2;

    drive(w, a, d, wd, wr, 1'b1);
    cyc = 0; stN = 0; misN = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cyc++;
      if (misOf(w)) misN++;
      if (!stallOf(w)) break;
      stN++;
      @(posedge clk); #1;
    end
    chk({tag, "/cycles"}, cyc, expTot);
    chk({tag, "/stall"}, stN, expTot - 1);
    chk({tag, "/mis"}, misN, al ? 0 : 1);
    chk({tag, "/rdata"}, rdOf(w), lastRd[w]);
    @(posedge clk); #1;
  endtask

  initial begin
    lastRd[0] = '0; lastRd[1] = '0;
    ldCnt[0] = 0; ldCnt[1] = 0; stCnt[0] = 0; stCnt[1] = 0;
    reset1 = 1'b1; reset0 = 1'b1;
    idle(1); idle(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst1/rd", i1.ReadDataM, 32'h0);
    chk("rst1/mis", {31'h0, i1.MisalignM}, 32'h0);
    chk("rst1/stall", {31'h0, i1.MemStallM}, 32'h0);
    chk("rst0/rd", i0.ReadDataM, 32'h0);
    chk("rst0/mis", {31'h0, i0.MisalignM}, 32'h0);
    chk("rst0/stall", {31'h0, i0.MemStallM}, 32'h0);
    reset1 = 1'b0; reset0 = 1'b0;
    @(posedge clk); #1;

    // Word store then load
    access(1, 32'h40, 32'hDEADBEEF, 2'b00, 1'b1, "st40");
    access(1, 32'h40, 32'h0, 2'b00, 1'b0, "ld40");
    chk("ld40/const", i1.ReadDataM, 32'hDEADBEEF);
    // Byte store into an existing word
    access(1, 32'h80, 32'h11223344, 2'b00, 1'b1, "st80");
    access(1, 32'h82, 32'h000000AA, 2'b10, 1'b1, "sb82");
    access(1, 32'h80, 32'h0, 2'b00, 1'b0, "ld80");
    chk("ld80/const", i1.ReadDataM, 32'h11AA3344);
    // Halfword store
    access(1, 32'h84, 32'h0, 2'b00, 1'b1, "st84");
    access(1, 32'h86, 32'h0000BEEF, 2'b01, 1'b1, "sh86");
    access(1, 32'h84, 32'h0, 2'b00, 1'b0, "ld84");
    chk("ld84/const", i1.ReadDataM, 32'hBEEF0000);
    // Misaligned word store is dropped
    access(1, 32'h41, 32'h55555555, 2'b00, 1'b1, "st41mis");
    access(1, 32'h40, 32'h0, 2'b00, 1'b0, "ld40b");
    chk("ld40b/const", i1.ReadDataM, 32'hDEADBEEF);
    idle(1);

    // Write strobe without request is ignored
    drive(1, 32'h40, 32'h0, 2'b00, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wrNoReq/stall", {31'h0, i1.MemStallM}, 32'h0);
    end
    @(posedge clk); #1;
    access(1, 32'h40, 32'h0, 2'b00, 1'b0, "ld40c");
    idle(1);

    // Reset while BUSY aborts the store
    drive(1, 32'h40, 32'h12345678, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    chk("rstBusy/idleStall", {31'h0, i1.MemStallM}, 32'h1);
    @(posedge clk); #1;
    reset1 = 1'b1;
    #1;
    chk("rstBusy/stall", {31'h0, i1.MemStallM}, 32'h1);
    chk("rstBusy/rd", i1.ReadDataM, 32'h0);
    chk("rstBusy/mis", {31'h0, i1.MisalignM}, 32'h0);
    lastRd[1] = '0; ldCnt[1] = 0; stCnt[1] = 0;
    idle(1);
    #1;
    chk("rstBusy/stallNoReq", {31'h0, i1.MemStallM}, 32'h0);
    @(posedge clk); #1;
    reset1 = 1'b0;
    @(posedge clk); #1;
    access(1, 32'h40, 32'h0, 2'b00, 1'b0, "ldAfterRst");
    chk("ldAfterRst/const", i1.ReadDataM, 32'hDEADBEEF);
    idle(1);

    // Zero wait states, back-to-back
    access(0, 32'h10, 32'hA5A5A5A5, 2'b00, 1'b1, "w0st10");
    access(0, 32'h14, 32'h0BADF00D, 2'b00, 1'b1, "w0st14");
    access(0, 32'h10, 32'h0, 2'b00, 1'b0, "w0ld10");
    access(0, 32'h14, 32'h0, 2'b00, 1'b0, "w0ld14");
    chk("w0ld14/const", i0.ReadDataM, 32'h0BADF00D);
    access(0, 32'h10, 32'h0, 2'b00, 1'b0, "w0ld10b");
    idle(0);
`ifdef DMEM_PERF_CNT_EN
    chk("w0/loadCnt", ldc0, 32'd3);
    chk("w0/storeCnt", stc0, 32'd2);
`endif

    // Random traffic over a pre-initialised window, with aliased upper bits
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 8; k++) begin
        access(w, 32'h200 + 32'(k * 4), $urandom, 2'b00, 1'b1, "init");
      end
      idle(w);
    end
    for (int i = 0; i < 60; i++) begin
      int w;
      logic [31:0] a;
      w = int'($urandom_range(0, 1));
      a = 32'h200 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      a = a | ($urandom & 32'hFFFF_F000);
      access(w, a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $sformatf("rnd%0d", i));
      idle(w);
    end

`ifdef DMEM_PERF_CNT_EN
    chk("perf1/load", ldc1, ldCnt[1]);
    chk("perf1/store", stc1, stCnt[1]);
    chk("perf0/load", ldc0, ldCnt[0]);
    chk("perf0/store", stc0, stCnt[0]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
